// File: rtl/i2s_rx.sv
// I2S master receiver: generates SCK/WS from clk, deserialises Philips-format
// I2S from a stereo MEMS mic pair and emits one valid pulse per frame.
`timescale 1ns/1ps

module i2s_rx #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned DATA_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sd,
  output logic                 sck,
  output logic                 ws,
  output logic [DATA_BITS-1:0] left_data,
  output logic [DATA_BITS-1:0] right_data,
  output logic                 valid
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(2 * SLOT_BITS);

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(2 * SLOT_BITS - 1);
  localparam logic [BitW-1:0] SlotEnd = BitW'(SLOT_BITS);

  logic                 sd_meta_q, sd_meta_d;
  logic                 sd_sync_q, sd_sync_d;
  logic [DivW-1:0]      div_cnt_q, div_cnt_d;
  logic                 sck_q, sck_d;
  logic                 ws_q, ws_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SLOT_BITS-2:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 primed_q, primed_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] left_q, left_d;
  logic [DATA_BITS-1:0] right_q, right_d;

  logic                 toggle;
  logic                 fall;
  logic [SLOT_BITS-1:0] slot_word;

  // Two-flop synchroniser for the asynchronous mic data.
  always_comb begin
    sd_meta_d = sd;
    sd_sync_d = sd_meta_q;
  end

  // Clock divider, SCK generation, bit counter and word select.
  always_comb begin
    toggle    = en && (div_cnt_q == DivLast);
    fall      = toggle && sck_q;
    div_cnt_d = (!en || toggle) ? '0 : div_cnt_q + DivW'(1);
    sck_d     = en ? (sck_q ^ toggle) : 1'b0;
    bit_cnt_d = bit_cnt_q;
    if (!en) begin
      bit_cnt_d = '0;
    end else if (fall) begin
      bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + BitW'(1);
    end
    // Follows the counter, so WS only moves on an SCK fall.
    ws_d = (bit_cnt_d >= SlotEnd);
  end

  // Shift in data on each SCK fall, latch left slot, publish the stereo pair.
  always_comb begin
    // Full slot as it stands once this cycle's bit is included.
    slot_word  = {shift_q, sd_sync_q};
    shift_d    = fall ? slot_word[SLOT_BITS-2:0] : shift_q;
    hold_d     = hold_q;
    primed_d   = primed_q;
    valid_d    = 1'b0;
    left_d     = left_q;
    right_d    = right_q;
    if (!en) begin
      primed_d = 1'b0;
    end else if (fall) begin
      if (bit_cnt_q == SlotEnd) begin
        hold_d   = slot_word[SLOT_BITS-1 -: DATA_BITS];
        primed_d = 1'b1;
      end
      // k==0 carries the right slot's last bit; only publish a complete frame.
      if ((bit_cnt_q == '0) && primed_q) begin
        valid_d = 1'b1;
        left_d  = hold_q;
        right_d = slot_word[SLOT_BITS-1 -: DATA_BITS];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_meta_q <= 1'b0;
      sd_sync_q <= 1'b0;
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
      primed_q  <= 1'b0;
      valid_q   <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
    end else begin
      sd_meta_q <= sd_meta_d;
      sd_sync_q <= sd_sync_d;
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      primed_q  <= primed_d;
      valid_q   <= valid_d;
      left_q    <= left_d;
      right_q   <= right_d;
    end
  end

  assign sck        = sck_q;
  assign ws         = ws_q;
  assign valid      = valid_q;
  assign left_data  = left_q;
  assign right_data = right_q;

endmodule
